controle_elevador: RTL

- Sequencing controller for the single elevator car over 16 floors (0..15), driven directly by the raw 16-bit call-button bus.
- Latches button presses into a pending-call register and schedules service with SCAN: keep direction while calls lie ahead, otherwise reverse.
- Drives motor up/down and door commands and times floor travel and door dwell with one shared counter.

---
 rtl/controle_elevador.sv | 134 +++++++++++++
 1 files changed

// File: rtl/controle_elevador.sv
// SCAN sequencing controller for a 16-floor elevator car: latches calls, drives
// motor/door commands, and times travel and door dwell with one shared counter.
module controle_elevador #(
  parameter int T_ANDAR = 8,
  parameter int T_PORTA = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] B,
  output logic [3:0]  andar_atual,
  output logic        motor_sobe,
  output logic        motor_desce,
  output logic        porta_aberta,
  output logic [15:0] pendentes,
  output logic        ocupado
);

  localparam int TMAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {PARADO, MOVENDO, PORTA} estado_t;

  estado_t       estado, estado_n;
  logic          dir, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    andar_n, prox;
  logic [15:0]   pend_n, clr, aqui_bit;
  logic          sobe_n, desce_n, porta_n, ocup_n;

  function automatic logic acima_de(input logic [15:0] v, input logic [3:0] f);
    logic [15:0] m;
    m = '1;
    m = m << f;
    m = m << 1;
    return |(v & m);
  endfunction

  function automatic logic abaixo_de(input logic [15:0] v, input logic [3:0] f);
    logic [15:0] m;
    m = '1;
    m = ~(m << f);
    return |(v & m);
  endfunction

  assign aqui_bit = 16'd1 << andar_atual;
  assign prox     = dir ? andar_atual + 4'd1 : andar_atual - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= PARADO;
      dir          <= 1'b1;
      cnt          <= '0;
      andar_atual  <= '0;
      pendentes    <= '0;
      motor_sobe   <= 1'b0;
      motor_desce  <= 1'b0;
      porta_aberta <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      estado       <= estado_n;
      dir          <= dir_n;
      cnt          <= cnt_n;
      andar_atual  <= andar_n;
      pendentes    <= pend_n;
      motor_sobe   <= sobe_n;
      motor_desce  <= desce_n;
      porta_aberta <= porta_n;
      ocupado      <= ocup_n;
    end
  end

  // An idle car treats a raw press at its own floor as served immediately,
  // so that call never shows up in pendentes.
  always_comb begin
    estado_n = estado;
    dir_n    = dir;
    cnt_n    = cnt;
    andar_n  = andar_atual;
    clr      = '0;
    unique case (estado)
      PARADO: begin
        if (pendentes[andar_atual] || B[andar_atual]) begin
          estado_n = PORTA;
          cnt_n    = CW'(T_PORTA - 1);
          clr      = aqui_bit;
        end else if (acima_de(pendentes, andar_atual) &&
                     (dir || !abaixo_de(pendentes, andar_atual))) begin
          dir_n    = 1'b1;
          estado_n = MOVENDO;
          cnt_n    = CW'(T_ANDAR - 1);
        end else if (abaixo_de(pendentes, andar_atual)) begin
          dir_n    = 1'b0;
          estado_n = MOVENDO;
          cnt_n    = CW'(T_ANDAR - 1);
        end
      end
      MOVENDO: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          andar_n = prox;
          if (pendentes[prox]) begin
            estado_n = PORTA;
            cnt_n    = CW'(T_PORTA - 1);
          end else if (dir ? acima_de(pendentes, prox) : abaixo_de(pendentes, prox)) begin
            cnt_n = CW'(T_ANDAR - 1);
          end else begin
            estado_n = PARADO;
          end
        end
      end
      PORTA: begin
        clr = aqui_bit;
        if (B[andar_atual]) begin
          cnt_n = CW'(T_PORTA - 1);
        end else if (cnt == '0) begin
          estado_n = PARADO;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: estado_n = PARADO;
    endcase
    pend_n = (pendentes | B) & ~clr;
  end

  always_comb begin
    sobe_n  = (estado_n == MOVENDO) && dir_n;
    desce_n = (estado_n == MOVENDO) && !dir_n;
    porta_n = (estado_n == PORTA);
    ocup_n  = (estado_n != PARADO) || (pend_n != '0);
  end

endmodule
